// File: rtl/alu_operand_regfile.sv
// 2**ADDR_W x DATA_W register file with two combinational read ports, one write port,
// optional same-cycle write-to-read bypass, a debug read port and a saturating write counter.
module alu_operand_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] dbg_reg,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       write_count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [15:0]       count_q;
    logic [15:0]       count_d;
    logic              wr_en;
    logic              byp_hit1;
    logic              byp_hit2;

    // reg_write is tested first so an unknown write_reg with no write pending cannot leak into state.
    assign wr_en = reg_write && (write_reg != '0);

    always_comb begin
        count_d = count_q;
        if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
            count_q           <= count_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] idx,
        input logic              hit,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        if (idx == '0) begin
            return '0;
        end
        if (hit) begin
            return wdata;
        end
        return stored;
    endfunction

    // Bypass is suppressed during reset so every read port shows zero while rst is high.
    assign byp_hit1 = (BYPASS != 0) && !rst && wr_en && (write_reg == read_reg1);
    assign byp_hit2 = (BYPASS != 0) && !rst && wr_en && (write_reg == read_reg2);

    assign read_data1  = read_port(read_reg1, byp_hit1, write_data, regs_q[read_reg1]);
    assign read_data2  = read_port(read_reg2, byp_hit2, write_data, regs_q[read_reg2]);
    assign dbg_data    = (dbg_reg == '0) ? '0 : regs_q[dbg_reg];
    assign write_count = count_q;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Scoreboard bench for alu_operand_regfile: one bypassing and one non-bypassing instance share stimulus
// and are compared against an array-based reference model of the register file.
module tb_alu_operand_regfile;
    logic        clk;
    logic        rst;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [4:0]  dbg_reg;

    logic [31:0] rd1_b, rd2_b, dbg_b;
    logic [15:0] cnt_b;
    logic [31:0] rd1_n, rd2_n, dbg_n;
    logic [15:0] cnt_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd1_b;
        logic [31:0] rd2_b;
        logic [31:0] rd1_n;
        logic [31:0] rd2_n;
        logic [31:0] dbg;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [32];
    int          mdl_cnt;
    bit          stim_done = 0;

    alu_operand_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .dbg_reg(dbg_reg), .read_data1(rd1_b), .read_data2(rd2_b),
        .dbg_data(dbg_b), .write_count(cnt_b)
    );

    alu_operand_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .dbg_reg(dbg_reg), .read_data1(rd1_n), .read_data2(rd2_n),
        .dbg_data(dbg_n), .write_count(cnt_n)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a register holds the last value written to it; index 0 is always zero;
    // a bypassing port sees this cycle's write data, a plain port sees the stored value.
    function automatic logic [31:0] model_read(input logic [4:0] idx, input bit byp, input logic rstv,
                                               input logic we, input logic [4:0] wr, input logic [31:0] wd);
        if (rstv || idx == 0) return 32'h0;
        if (byp && we && wr == idx) return wd;
        return mdl[idx];
    endfunction

    task automatic drive(input logic rstv, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rstv; reg_write = we; write_reg = wr; write_data = wd;
        read_reg1 = r1; read_reg2 = r2; dbg_reg = dr;
        if (rstv) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mdl_cnt = 0;
        end
        e.rd1_b = model_read(r1, 1'b1, rstv, we, wr, wd);
        e.rd2_b = model_read(r2, 1'b1, rstv, we, wr, wd);
        e.rd1_n = model_read(r1, 1'b0, rstv, we, wr, wd);
        e.rd2_n = model_read(r2, 1'b0, rstv, we, wr, wd);
        e.dbg   = (dr == 0) ? 32'h0 : mdl[dr];
        e.cnt   = 16'(mdl_cnt);
        exp_q.push_back(e);
        if (!rstv && we && wr != 0) begin
            mdl[wr] = wd;
            if (mdl_cnt < 65535) mdl_cnt++;
        end
    endtask

    // Monitor: outputs are combinational, so each cycle's expectation is checked mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd1_byp", rd1_b, e.rd1_b);
                chk("rd2_byp", rd2_b, e.rd2_b);
                chk("rd1_nobyp", rd1_n, e.rd1_n);
                chk("rd2_nobyp", rd2_n, e.rd2_n);
                chk("dbg_byp", dbg_b, e.dbg);
                chk("dbg_nobyp", dbg_n, e.dbg);
                chk("cnt_byp", {16'h0, cnt_b}, {16'h0, e.cnt});
                chk("cnt_nobyp", {16'h0, cnt_n}, {16'h0, e.cnt});
            end
        end
    end

    initial begin
        rst = 1; reg_write = 0; write_reg = 0; write_data = 0;
        read_reg1 = 0; read_reg2 = 0; dbg_reg = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mdl_cnt = 0;

        // Reset state across every index.
        for (int i = 0; i < 32; i++) drive(1, 0, 5'(i), 32'h0, 5'(i), 5'(31 - i), 5'(i));

        // Basic writes then reads.
        drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        drive(0, 1, 7, 32'h0000FFFF, 5, 7, 5);
        drive(0, 0, 5'bx, 32'hx, 5, 7, 7);
        // Unknown write_reg with no write pending must not disturb state.
        drive(0, 0, 5'bx, 32'h12345678, 5, 7, 5);

        // Write to r0 is discarded and not counted.
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 5, 0);

        // Same-cycle write/read of one register.
        drive(0, 1, 9, 32'h00000001, 0, 0, 9);
        drive(0, 1, 9, 32'hA5A5A5A5, 9, 9, 9);
        drive(0, 0, 0, 32'h0, 9, 9, 9);

        // Asynchronous reset mid-cycle while a write is pending.
        drive(0, 1, 3, 32'h12345678, 3, 3, 3);
        drive(0, 0, 0, 32'h0, 3, 4, 3);
        drive(1, 1, 4, 32'hCAFEF00D, 3, 4, 4);
        drive(0, 0, 0, 32'h0, 3, 4, 3);
        drive(0, 0, 0, 32'h0, 4, 3, 4);

        // Randomized traffic on a narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        // Counter saturation.
        drive(1, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) begin
            drive(0, 1, 1, 32'(i) ^ 32'h5A5A0000, 1, 2, 1);
        end
        drive(0, 0, 0, 32'h0, 1, 1, 1);
        drive(0, 0, 0, 32'h0, 1, 0, 1);

        stim_done = 1;
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
